vecmat_reduce_pipe: RTL and testbench
=====================================

# vecmat_reduce_pipe

Parametrised, pipelined adder-tree reduction for the attention-layer vector/matrix datapath. Sums NUM_ELEMS signed fixed-point lanes of one input beat, optionally accumulates ACC_BEATS consecutive beats, and emits one scalar per group with a ready/valid handshake. Supports configurable pipeline depth, wrap or saturating arithmetic, and a per-result overflow flag. Sits between the element-wise multiplier array and the score/output buffers.

## Interface
- DATA_WIDTH, 16: lane and result width, two's complement.
- NUM_ELEMS, 64: lanes per beat; power of two, ≥2.
- STAGE_LEVELS, 2: tree levels between pipeline registers; 1..log2(NUM_ELEMS).
- SATURATE, 0: 0 = modulo 2^DATA_WIDTH wrap; 1 = signed saturation at every adder.
- ACC_BEATS, 1: input beats summed into one result; ≥1.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  NUM_ELEMS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data/out_ovf hold a result.
- out_ready  in  1  consumer takes the result.
- out_data  out  DATA_WIDTH  reduced sum.
- out_ovf  out  1  any adder in this result's computation overflowed.

## Operation
- Tree: L = log2(NUM_ELEMS) levels; level k pairs node 2j (operand a) with 2j+1 (operand b). Pairing order is fixed; results are bit-exact with this order in saturating mode.
- Register stage after every STAGE_LEVELS levels and always after level L; NS = ceil(L/STAGE_LEVELS) stages. Each stage carries data, a valid bit and a sticky ovf bit (OR of its inputs' ovf and local adder overflows).
- Adder: signed overflow = operands same sign, sum sign differs. SATURATE=1: positive overflow → 0x7FFF-equivalent (max), negative → min (0x8000 for 16 bits). SATURATE=0: wrap, ovf still reported.
- Accumulator: acc register, acc_ovf, beat counter 0..ACC_BEATS-1. On each valid tree output: if count < ACC_BEATS-1, acc ← acc + sum (same adder rules), count++; on the last beat load out_data ← acc + sum, out_ovf ← all sticky bits, out_valid ← 1, acc/count/acc_ovf cleared. ACC_BEATS=1: out_data = tree sum.
- Flow control: global enable en = !out_valid | out_ready; in_ready = en. When en=0 every stage, counter and acc hold. Beat accepted when in_valid & in_ready.
- Reset: out_valid=0, out_data=0, out_ovf=0, all stage valids/ovfs, acc, counter cleared; in_ready=1 after reset. Reset mid-operation discards all in-flight beats and partial accumulations; no result emitted for them.

## Timing
- Latency: beat accepted at cycle t (final beat of group) → out_valid at t+NS+1 with no stall. Defaults (L=6, STAGE_LEVELS=2): NS=3, latency 4.
- Throughput: one beat per cycle when out_ready stays high; one result per ACC_BEATS beats.
- Stall: out_valid & !out_ready freezes whole pipe; out_data/out_ovf stable until handshake. Handshake and new result in the same cycle allowed (en=1).
- in_ready is combinational from out_valid/out_ready only; no path from in_valid.

## Structure
- Package vecmat_pkg: DATA_WIDTH default, sat max/min constants, lane-slice helper.
- Sub-module vecmat_sat_add (combinational: a, b → sum, ovf, SATURATE parameter), instantiated per tree node and for the accumulator; tree built with generate loops.

## Test plan
- All 64 lanes 0x0001, defaults → out_data 0x0040, out_ovf 0, out_valid exactly 4 cycles after accept.
- All lanes 0x4000, SATURATE=1 → 0x7FFF, out_ovf 1; SATURATE=0 → 0x0000, out_ovf 1; lanes 0xC000, SATURATE=1 → 0x8000.
- ACC_BEATS=4, four back-to-back beats of lanes 0x0001 → single result 0x0100, one out_valid pulse; 8 beats → two results.
- Backpressure: out_ready low 3 cycles with beats streaming → in_ready low, out_data stable, no beat lost or duplicated; scoreboard matches.
- Reset asserted after 2 of 4 accumulated beats → no output; next full group yields exact sum with no residue.
- Random lanes/stalls, STAGE_LEVELS 1..6 → matches reference model in pairing order; latency = NS+1.

Source files
------------

// File: rtl/vecmat_pkg.sv
// Shared constants and helpers for the vecmat reduction datapath.
// Saturation limits are width-generic so every adder instance can share them.
package vecmat_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    // Largest positive two's-complement value of a w-bit word (0x7FFF for 16 bits).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (0x8000 for 16 bits).
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // LSB position of lane i inside a flat beat of w-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/vecmat_sat_add.sv
// Combinational two's-complement adder with signed-overflow detect and
// optional saturation; used for every tree node and for the accumulator.
module vecmat_sat_add
    import vecmat_pkg::*;
#(
    parameter int W        = DATA_WIDTH_DEF,
    parameter int SATURATE = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W));

    logic [W-1:0] raw;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum = raw;
        if ((SATURATE != 0) && ovf) begin
            sum = a[W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/vecmat_reduce_pipe.sv
// Pipelined adder-tree reduction of NUM_ELEMS lanes per beat, followed by an
// ACC_BEATS-beat accumulator and a ready/valid output register.
module vecmat_reduce_pipe
    import vecmat_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_ELEMS    = 64,
    parameter int STAGE_LEVELS = 2,
    parameter int SATURATE     = 0,
    parameter int ACC_BEATS    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_ELEMS*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_ovf
);

    localparam int L  = $clog2(NUM_ELEMS);
    localparam int CW = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_BEATS - 1);

    logic en;

    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_d,  out_data_q;
    logic                  out_ovf_d,   out_ovf_q;

    // One global enable freezes the whole pipe while a result waits for the consumer.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Level 0 is the raw beat; level k pairs nodes 2j/2j+1 of level k-1.
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int CNT = NUM_ELEMS >> k;

        logic [DATA_WIDTH-1:0] node_out [CNT];
        logic                  vld_out;
        logic                  ovf_out;

        if (k == 0) begin : g_in
            for (genvar j = 0; j < CNT; j++) begin : g_lane
                assign node_out[j] = in_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
            end
            assign vld_out = in_valid && en;
            assign ovf_out = 1'b0;
        end else begin : g_add
            logic [DATA_WIDTH-1:0] sum_w [CNT];
            logic [CNT-1:0]        add_ovf;
            logic                  lvl_ovf;

            for (genvar j = 0; j < CNT; j++) begin : g_node
                vecmat_sat_add #(
                    .W        (DATA_WIDTH),
                    .SATURATE (SATURATE)
                ) u_add (
                    .a   (g_lvl[k-1].node_out[2*j]),
                    .b   (g_lvl[k-1].node_out[2*j+1]),
                    .sum (sum_w[j]),
                    .ovf (add_ovf[j])
                );
            end

            // Sticky overflow: anything upstream in this beat, plus this level's adders.
            assign lvl_ovf = g_lvl[k-1].ovf_out || (|add_ovf);

            if (((k % STAGE_LEVELS) == 0) || (k == L)) begin : g_reg
                logic [DATA_WIDTH-1:0] node_d [CNT];
                logic [DATA_WIDTH-1:0] node_q [CNT];
                logic                  vld_d, vld_q;
                logic                  ovf_d, ovf_q;

                always_comb begin
                    node_d = node_q;
                    vld_d  = vld_q;
                    ovf_d  = ovf_q;
                    if (en) begin
                        node_d = sum_w;
                        vld_d  = g_lvl[k-1].vld_out;
                        ovf_d  = lvl_ovf;
                    end
                end

                // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
                // NOTE: datapath registers are reset too, so a stalled or idle pipe never shows stale sums.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        node_q <= '{default: '0};
                        vld_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                    end else begin
                        node_q <= node_d;
                        vld_q  <= vld_d;
                        ovf_q  <= ovf_d;
                    end
                end

                assign node_out = node_q;
                assign vld_out  = vld_q;
                assign ovf_out  = ovf_q;
            end else begin : g_comb
                assign node_out = sum_w;
                assign vld_out  = g_lvl[k-1].vld_out;
                assign ovf_out  = lvl_ovf;
            end
        end
    end

    logic [DATA_WIDTH-1:0] tree_sum;
    logic                  tree_vld;
    logic                  tree_ovf;

    assign tree_sum = g_lvl[L].node_out[0];
    assign tree_vld = g_lvl[L].vld_out;
    assign tree_ovf = g_lvl[L].ovf_out;

    logic [DATA_WIDTH-1:0] acc_d, acc_q, acc_sum;
    logic                  acc_ovf_d, acc_ovf_q, acc_add_ovf;
    logic [CW-1:0]         cnt_d, cnt_q;

    vecmat_sat_add #(
        .W        (DATA_WIDTH),
        .SATURATE (SATURATE)
    ) u_acc_add (
        .a   (acc_q),
        .b   (tree_sum),
        .sum (acc_sum),
        .ovf (acc_add_ovf)
    );

    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (tree_vld) begin
                if (cnt_q != LAST_BEAT) begin
                    acc_d     = acc_sum;
                    acc_ovf_d = acc_ovf_q || tree_ovf || acc_add_ovf;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    // Last beat of the group: publish and start the next group from zero.
                    out_valid_d = 1'b1;
                    out_data_d  = acc_sum;
                    out_ovf_d   = acc_ovf_q || tree_ovf || acc_add_ovf;
                    acc_d       = '0;
                    acc_ovf_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_vecmat_reduce_pipe.sv
// Scoreboard bench: two DUTs (wrap/ACC=1 and saturate/ACC=4) share one beat stream;
// a reference model pushes expected results and a negedge monitor pops and compares.
module tb_vecmat_reduce_pipe;

    parameter int SL_B = 3;

    localparam int W     = 16;
    localparam int N     = 64;
    localparam int L     = 6;
    localparam int SL_A  = 2;
    localparam int NS_A  = (L + SL_A - 1) / SL_A;
    localparam int NS_B  = (L + SL_B - 1) / SL_B;
    localparam int ACC_B = 4;
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    typedef struct {
        logic [W-1:0] data;
        bit           ovf;
        int           exp_cyc;
    } exp_t;

    exp_t q [2][$];

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic [N*W-1:0] in_data;
    logic           out_valid_a, out_valid_b, out_ovf_a, out_ovf_b;
    logic [W-1:0]   out_data_a, out_data_b;

    logic           ov   [2];
    logic [W-1:0]   od   [2];
    logic           oo   [2];
    logic           ordy [2] = '{1'b1, 1'b1};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rdy_mode    = 0;   // 0: always ready, 1: random, 2: ready except stall window
    int stall_until = 0;

    int acc_val = 0;
    bit acc_ovf = 1'b0;
    int acc_cnt = 0;

    assign ov[0] = out_valid_a;
    assign ov[1] = out_valid_b;
    assign od[0] = out_data_a;
    assign od[1] = out_data_b;
    assign oo[0] = out_ovf_a;
    assign oo[1] = out_ovf_b;

    vecmat_reduce_pipe #(
        .DATA_WIDTH(W), .NUM_ELEMS(N), .STAGE_LEVELS(SL_A), .SATURATE(0), .ACC_BEATS(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(ordy[0]),
        .out_data(out_data_a), .out_ovf(out_ovf_a)
    );

    vecmat_reduce_pipe #(
        .DATA_WIDTH(W), .NUM_ELEMS(N), .STAGE_LEVELS(SL_B), .SATURATE(1), .ACC_BEATS(ACC_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(ordy[1]),
        .out_data(out_data_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Integer-domain adder: overflow is simply leaving the representable range.
    function automatic void add_ref(input int a, input int b, input bit sat,
                                    output int r, output bit o);
        int s;
        s = a + b;
        o = (s > MAXV) || (s < MINV);
        if (!o)       r = s;
        else if (sat) r = (s > MAXV) ? MAXV : MINV;
        else          r = (s > MAXV) ? s - (1 << W) : s + (1 << W);
    endfunction

    function automatic void tree_ref(input int lanes [N], input bit sat,
                                     output int sum, output bit ovf);
        int v [N];
        int r;
        bit o;
        v   = lanes;
        ovf = 1'b0;
        for (int w = N; w > 1; w = w / 2) begin
            for (int j = 0; j < w / 2; j++) begin
                add_ref(v[2*j], v[2*j+1], sat, r, o);
                v[j] = r;
                ovf  = ovf | o;
            end
        end
        sum = v[0];
    endfunction

    task automatic model_accept(input int lanes [N]);
        int   s, r;
        bit   o, o2;
        exp_t e;
        tree_ref(lanes, 1'b0, s, o);
        e.data    = W'(s);
        e.ovf     = o;
        e.exp_cyc = (rdy_mode == 0) ? cyc + NS_A + 1 : -1;
        q[0].push_back(e);

        tree_ref(lanes, 1'b1, s, o);
        add_ref(acc_val, s, 1'b1, r, o2);
        acc_ovf = acc_ovf | o | o2;
        acc_cnt++;
        if (acc_cnt == ACC_B) begin
            e.data    = W'(r);
            e.ovf     = acc_ovf;
            e.exp_cyc = (rdy_mode == 0) ? cyc + NS_B + 1 : -1;
            q[1].push_back(e);
            acc_val = 0;
            acc_ovf = 1'b0;
            acc_cnt = 0;
        end else begin
            acc_val = r;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic send_beat(input int lanes [N]);
        logic [N*W-1:0] d;
        int guard = 0;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(lanes[i]);
        forever begin
            @(negedge clk);
            #1;
            if (cyc < stall_until) begin
                if (ov[0] && !ordy[0]) check("in_ready_a_stall", in_ready_a, 0);
                if (ov[1] && !ordy[1]) check("in_ready_b_stall", in_ready_b, 0);
            end
            if (in_ready_a && in_ready_b) break;
            in_valid_a = 1'b0;
            in_valid_b = 1'b0;
            guard++;
            if (guard > 100) begin
                check("in_ready_timeout", guard, 0);
                return;
            end
        end
        in_valid_a = 1'b1;
        in_valid_b = 1'b1;
        in_data    = d;
        model_accept(lanes);
    endtask

    task automatic send_const(input int val, input int beats);
        int lanes [N];
        for (int i = 0; i < N; i++) lanes[i] = val;
        for (int b = 0; b < beats; b++) send_beat(lanes);
    endtask

    task automatic send_random();
        int lanes [N];
        bit wide;
        wide = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N; i++)
            lanes[i] = wide ? int'($urandom_range(0, 65535)) - 32768
                            : int'($urandom_range(0, 600)) - 300;
        send_beat(lanes);
    endtask

    task automatic drain();
        int guard = 0;
        idle();
        while ((q[0].size() + q[1].size()) != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", q[0].size() + q[1].size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: chooses out_ready for the coming edge, then scores any handshake.
    logic         held_v [2] = '{1'b0, 1'b0};
    logic [W-1:0] held_d [2];
    logic         held_o [2];
    exp_t         mon_e;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                ordy[d]   = 1'b1;
                held_v[d] = 1'b0;
                continue;
            end
            if (held_v[d]) begin
                check($sformatf("hold%0d_valid", d), ov[d], 1);
                check($sformatf("hold%0d_data", d), od[d], held_d[d]);
                check($sformatf("hold%0d_ovf", d), oo[d], held_o[d]);
            end
            if (rdy_mode == 0)      ordy[d] = 1'b1;
            else if (rdy_mode == 2) ordy[d] = !(cyc < stall_until);
            else                    ordy[d] = ($urandom_range(0, 3) != 0);
            if (ov[d] && ordy[d]) begin
                if (q[d].size() == 0) begin
                    check($sformatf("unexpected_out%0d", d), 1, 0);
                end else begin
                    mon_e = q[d].pop_front();
                    check($sformatf("out%0d_data", d), od[d], mon_e.data);
                    check($sformatf("out%0d_ovf", d), oo[d], mon_e.ovf);
                    if (mon_e.exp_cyc >= 0)
                        check($sformatf("out%0d_latency_cycle", d), cyc, mon_e.exp_cyc);
                end
            end
            held_v[d] = ov[d] && !ordy[d];
            held_d[d] = od[d];
            held_o[d] = oo[d];
        end
    end

    initial begin
        reset      = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data    = '0;
        repeat (3) @(negedge clk);
        check("rst_a_valid", out_valid_a, 0);
        check("rst_a_data", out_data_a, 0);
        check("rst_a_ovf", out_ovf_a, 0);
        check("rst_a_in_ready", in_ready_a, 1);
        check("rst_b_valid", out_valid_b, 0);
        check("rst_b_data", out_data_b, 0);
        check("rst_b_ovf", out_ovf_b, 0);
        check("rst_b_in_ready", in_ready_b, 1);
        #1 reset = 1'b0;

        // Unit lanes: 0x0040 per beat, 0x0100 per four-beat group; 12 beats -> 3 groups.
        rdy_mode = 0;
        send_const(1, 4);
        send_const(1, 8);
        drain();

        // Overflow corners: wrap to zero, saturate to max / min.
        send_const(16384, 4);
        send_const(-16384, 4);
        drain();

        // Directed backpressure window while beats keep streaming.
        rdy_mode = 2;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) stall_until = cyc + 4;
            send_random();
        end
        drain();
        stall_until = 0;

        // Reset after two of four accumulated beats: partial group must vanish.
        rdy_mode = 0;
        send_random();
        send_random();
        idle();
        repeat (10) @(negedge clk);
        check("pre_reset_pending", q[0].size() + q[1].size(), 0);
        #1 reset = 1'b1;
        acc_val = 0;
        acc_ovf = 1'b0;
        acc_cnt = 0;
        repeat (2) @(negedge clk);
        check("midrst_b_valid", out_valid_b, 0);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post_reset_b_valid", out_valid_b, 0);
        send_const(3, 4);
        drain();

        // Random lanes with random stalls and input gaps.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_random();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
